// File: rtl/dma_pkg.sv
// Shared definitions for the DMA bulk mover: FSM state encoding, bus
// geometry defaults and small address helpers.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int DEF_DATA_W = 1024;
  localparam int DEF_WORD_W = 32;
  localparam int BEATS      = DEF_DATA_W / DEF_WORD_W;
  localparam int BEAT_CNT_W = $clog2(BEATS);

  // A base address is only usable when it is 32-bit word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dma_beat_timer.sv
// Per-beat response watchdog for the DMA bulk mover. Counts cycles spent
// waiting for a memory response and flags expiry after TIMEOUT_CYCLES.
// Only instantiated when DMA_TIMEOUT_EN is defined.
module dma_beat_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_run,
  output logic o_expired
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count while waiting, restart whenever the wait ends; saturate at the limit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (!i_run) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Expiry fires on the TIMEOUT_CYCLES-th waiting cycle.
  assign o_expired = i_run && (r_cnt == LIMIT);

endmodule

// File: rtl/dma_bulk_mover.sv
// DMA responder moving one DATA_W operand to/from memory as a sequence of
// WORD_W beats over a single-outstanding request/response bus.
// Optional feature: define DMA_TIMEOUT_EN to add a per-beat response watchdog.
module dma_bulk_mover
  import dma_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WORD_W = DEF_WORD_W
`ifdef DMA_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              dma_rx_start,
  input  logic [31:0]       dma_rx_address,
  output logic [DATA_W-1:0] dma_rx_data,
  input  logic              dma_tx_start,
  input  logic [31:0]       dma_tx_address,
  input  logic [DATA_W-1:0] dma_tx_data,
  output logic              dma_done,
  output logic              dma_idle,
  output logic              dma_error,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [31:0]       mem_req_addr,
  output logic [WORD_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [WORD_W-1:0] mem_rsp_rdata,
  input  logic              mem_rsp_err
);

  localparam int               L_BEATS   = DATA_W / WORD_W;
  localparam int               BEAT_W    = (L_BEATS > 1) ? $clog2(L_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(L_BEATS - 1);

  state_t              r_state;
  state_t              w_next;
  logic [BEAT_W-1:0]   r_beat;
  logic [31:0]         r_addr;
  logic [DATA_W-1:0]   r_shreg;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_req_we;
  logic                r_req_valid;
  logic                r_done;
  logic                r_idle;
  logic                r_error;

  logic                w_start;
  logic                w_misaligned;
  logic                w_last;
  logic                w_timeout;
  logic [31:0]         w_start_addr;
  logic [DATA_W-1:0]   w_shreg_next;

  // rx wins when both starts arrive together.
  assign w_start      = dma_rx_start | dma_tx_start;
  assign w_start_addr = dma_rx_start ? dma_rx_address : dma_tx_address;
  assign w_misaligned = is_misaligned(w_start_addr);
  assign w_last       = (r_beat == LAST_BEAT);
  // Reads shift the new word in at the top; writes shift zeros in behind the outgoing word.
  assign w_shreg_next = {(r_req_we ? {WORD_W{1'b0}} : mem_rsp_rdata), r_shreg[DATA_W-1:WORD_W]};

`ifdef DMA_TIMEOUT_EN
  dma_beat_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_beat_timer (
    .clk       (clk),
    .resetn    (resetn),
    .i_run     (r_state == RSP),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: one request, one response per beat; errors jump to DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (w_misaligned) w_next = DONE;
          else              w_next = REQ;
        end else begin
          w_next = IDLE;
        end
      end
      REQ: begin
        if (mem_req_ready) w_next = RSP;
        else               w_next = REQ;
      end
      RSP: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_err || w_last) w_next = DONE;
          else                       w_next = REQ;
        end else if (w_timeout) begin
          w_next = DONE;
        end else begin
          w_next = RSP;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath and registered status/bus outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_beat      <= {BEAT_W{1'b0}};
      r_addr      <= 32'h0000_0000;
      r_shreg     <= {DATA_W{1'b0}};
      r_rx_data   <= {DATA_W{1'b0}};
      r_req_we    <= 1'b0;
      r_req_valid <= 1'b0;
      r_done      <= 1'b0;
      r_idle      <= 1'b1;
      r_error     <= 1'b0;
    end else begin
      r_req_valid <= (w_next == REQ);
      r_done      <= (w_next == DONE);
      r_idle      <= (w_next == IDLE);
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_error  <= w_misaligned;
            r_beat   <= {BEAT_W{1'b0}};
            r_req_we <= ~dma_rx_start;
            // Keep the bus address aligned: a misaligned base never reaches the bus.
            if (!w_misaligned) r_addr <= w_start_addr;
            else               r_addr <= r_addr;
            if (!dma_rx_start) r_shreg <= dma_tx_data;
            else               r_shreg <= r_shreg;
          end
        end
        RSP: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_err) begin
              r_error <= 1'b1;
            end else begin
              r_shreg <= w_shreg_next;
              r_beat  <= r_beat + BEAT_W'(1);
              r_addr  <= r_addr + 32'(WORD_BYTES);
              if (w_last && !r_req_we) r_rx_data <= w_shreg_next;
            end
          end else if (w_timeout) begin
            r_error <= 1'b1;
          end
        end
        default: begin
          r_beat <= r_beat;
        end
      endcase
    end
  end

  assign dma_rx_data   = r_rx_data;
  assign dma_done      = r_done;
  assign dma_idle      = r_idle;
  assign dma_error     = r_error;
  assign mem_req_valid = r_req_valid;
  assign mem_req_we    = r_req_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_req_we ? r_shreg[WORD_W-1:0] : {WORD_W{1'b0}};

endmodule

// File: tb/tb_dma_bulk_mover.sv
// Self-checking bench for dma_bulk_mover with a behavioural memory responder.
module tb_dma_bulk_mover;

  localparam int DW = 1024;
  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          dma_rx_start = 1'b0;
  logic [31:0]   dma_rx_address = 32'h0;
  logic [DW-1:0] dma_rx_data;
  logic          dma_tx_start = 1'b0;
  logic [31:0]   dma_tx_address = 32'h0;
  logic [DW-1:0] dma_tx_data = '0;
  logic          dma_done, dma_idle, dma_error;
  logic          mem_req_valid, mem_req_we;
  logic          mem_req_ready = 1'b0;
  logic [31:0]   mem_req_addr, mem_req_wdata;
  logic          mem_rsp_valid = 1'b0;
  logic [31:0]   mem_rsp_rdata = 32'h0;
  logic          mem_rsp_err = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  // memory model controls (written by tests only)
  bit          rand_ready = 1'b0;
  bit          rand_delay = 1'b0;
  bit          hold       = 1'b0;
  int          err_at     = -1;
  logic [31:0] rd_base    = 32'h1000_0000;

  // memory model state (written by responder only)
  int          rsp_total = 0;
  int          stab_viol = 0;
  logic [31:0] log_addr[$];
  bit          log_we[$];
  logic [31:0] log_wdata[$];

  always #5 clk = ~clk;

`ifdef DMA_TIMEOUT_EN
  dma_bulk_mover #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .dma_rx_start(dma_rx_start), .dma_rx_address(dma_rx_address), .dma_rx_data(dma_rx_data),
    .dma_tx_start(dma_tx_start), .dma_tx_address(dma_tx_address), .dma_tx_data(dma_tx_data),
    .dma_done(dma_done), .dma_idle(dma_idle), .dma_error(dma_error),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
  );
`else
  dma_bulk_mover dut (
    .clk(clk), .resetn(resetn),
    .dma_rx_start(dma_rx_start), .dma_rx_address(dma_rx_address), .dma_rx_data(dma_rx_data),
    .dma_tx_start(dma_tx_start), .dma_tx_address(dma_tx_address), .dma_tx_data(dma_tx_data),
    .dma_done(dma_done), .dma_idle(dma_idle), .dma_error(dma_error),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
  );
`endif

  // Memory responder: single outstanding request, works on the falling edge.
  initial begin
    bit pend = 1'b0;
    int pdelay = 0;
    logic [31:0] paddr = 32'h0;
    bit prev_stall = 1'b0;
    logic [31:0] s_addr = 32'h0, s_wdata = 32'h0;
    logic s_we = 1'b0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      mem_rsp_rdata = 32'h0;
      if (pend) begin
        if (pdelay == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = 32'hA500_0000 | ((paddr - rd_base) >> 2);
          mem_rsp_err   = (rsp_total == err_at);
          rsp_total++;
          pend = 1'b0;
        end else begin
          pdelay--;
        end
      end
      if (prev_stall && (!mem_req_valid || mem_req_addr !== s_addr ||
                         mem_req_we !== s_we || mem_req_wdata !== s_wdata))
        stab_viol++;
      mem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_req_valid && mem_req_ready) begin
        log_addr.push_back(mem_req_addr);
        log_we.push_back(mem_req_we);
        log_wdata.push_back(mem_req_wdata);
        if (!hold) begin
          pend   = 1'b1;
          pdelay = rand_delay ? $urandom_range(0, 5) : 0;
          paddr  = mem_req_addr;
        end
      end
      prev_stall = mem_req_valid && !mem_req_ready;
      s_addr  = mem_req_addr;
      s_we    = mem_req_we;
      s_wdata = mem_req_wdata;
    end
  end

  // Expected read operand: word k is 0xA500_0000 | k.
  function automatic logic [DW-1:0] rx_pattern();
    logic [DW-1:0] v;
    for (int k = 0; k < NB; k++) v[32*k +: 32] = 32'hA500_0000 | 32'(k);
    return v;
  endfunction

  // Issue one start; cycle 1 is the cycle after the accepting edge.
  task automatic do_xfer(input bit rx, input bit tx, input logic [31:0] rx_addr,
                         input logic [31:0] tx_addr, input logic [DW-1:0] wdata,
                         input bit change_tx, output int done_cyc, output int done_cnt,
                         output logic err1);
    @(negedge clk);
    dma_rx_start = rx; dma_tx_start = tx;
    dma_rx_address = rx_addr; dma_tx_address = tx_addr; dma_tx_data = wdata;
    done_cyc = -1; done_cnt = 0; err1 = 1'bx;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (n == 1) begin
        dma_rx_start = 1'b0; dma_tx_start = 1'b0;
        if (change_tx) dma_tx_data = ~wdata;
        err1 = dma_error;
        n_assert++;
        if (dma_idle !== 1'b0) begin n_fail++; $display("FAIL idle_low_c1 got %b want 0", dma_idle); end
      end
      if (dma_done === 1'b1) begin done_cnt++; if (done_cyc < 0) done_cyc = n; end
      if (done_cyc >= 0 && n == done_cyc + 1) begin
        n_assert++;
        if (dma_idle !== 1'b1 || dma_done !== 1'b0) begin
          n_fail++; $display("FAIL after_done idle=%b done=%b want 1/0", dma_idle, dma_done);
        end
        break;
      end
    end
    n_assert++;
    if (done_cyc < 0) begin n_fail++; $display("FAIL xfer_timeout no dma_done within 3000 cycles"); end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++;
    if (dma_idle !== 1'b1 || dma_done !== 1'b0 || dma_error !== 1'b0 || dma_rx_data !== '0 ||
        mem_req_valid !== 1'b0 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state idle=%b done=%b err=%b valid=%b we=%b addr=%h wdata=%h want 1/0/0/0/0/0/0",
               dma_idle, dma_done, dma_error, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if (dma_idle !== 1'b1 || mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle idle=%b valid=%b want 1/0", dma_idle, mem_req_valid);
    end
  endtask

  task automatic test_rx_basic();
    int b, dc, dn; logic e1; logic [DW-1:0] exp;
    exp = rx_pattern();
    rd_base = 32'h1000_0000; rand_ready = 1'b0; rand_delay = 1'b0;
    b = log_addr.size();
    do_xfer(1'b1, 1'b0, 32'h1000_0000, 32'h0, '0, 1'b0, dc, dn, e1);
    n_assert++;
    if (dc !== 65 || dn !== 1) begin n_fail++; $display("FAIL rx_done_cycle got cyc=%0d cnt=%0d want 65/1", dc, dn); end
    n_assert++;
    if (dma_error !== 1'b0) begin n_fail++; $display("FAIL rx_error got %b want 0", dma_error); end
    n_assert++;
    if (log_addr.size() - b !== NB) begin n_fail++; $display("FAIL rx_req_count got %0d want %0d", log_addr.size() - b, NB); end
    for (int k = 0; k < NB && b + k < log_addr.size(); k++) begin
      n_assert++;
      if (log_addr[b+k] !== 32'h1000_0000 + 32'(4*k) || log_we[b+k] !== 1'b0) begin
        n_fail++; $display("FAIL rx_req_addr beat %0d got %h we=%b want %h we=0", k, log_addr[b+k], log_we[b+k], 32'h1000_0000 + 32'(4*k));
      end
    end
    n_assert++;
    if (dma_rx_data[31:0] !== 32'hA500_0000 || dma_rx_data[1023:992] !== 32'hA500_001F) begin
      n_fail++; $display("FAIL rx_data_ends got %h/%h want a5000000/a500001f", dma_rx_data[31:0], dma_rx_data[1023:992]);
    end
    n_assert++;
    if (dma_rx_data !== exp) begin n_fail++; $display("FAIL rx_data_full got %h want %h", dma_rx_data[255:0], exp[255:0]); end
  endtask

  // tx write check shared by the deterministic and random write scenarios
  task automatic test_tx_run(input logic [31:0] base, input logic [DW-1:0] wd, input bit change);
    int b, dc, dn; logic e1;
    b = log_addr.size();
    do_xfer(1'b0, 1'b1, 32'h0, base, wd, change, dc, dn, e1);
    n_assert++;
    if (dn !== 1 || dma_error !== 1'b0) begin n_fail++; $display("FAIL tx_done got cnt=%0d err=%b want 1/0", dn, dma_error); end
    n_assert++;
    if (log_addr.size() - b !== NB) begin n_fail++; $display("FAIL tx_req_count got %0d want %0d", log_addr.size() - b, NB); end
    for (int k = 0; k < NB && b + k < log_addr.size(); k++) begin
      n_assert++;
      if (log_addr[b+k] !== base + 32'(4*k) || log_we[b+k] !== 1'b1 || log_wdata[b+k] !== wd[32*k +: 32]) begin
        n_fail++; $display("FAIL tx_beat %0d got addr=%h we=%b data=%h want %h/1/%h",
                           k, log_addr[b+k], log_we[b+k], log_wdata[b+k], base + 32'(4*k), wd[32*k +: 32]);
      end
    end
  endtask

  task automatic test_tx();
    logic [DW-1:0] wd;
    for (int k = 0; k < NB; k++) wd[32*k +: 32] = 32'(k) * 32'h0101_0101;
    rand_ready = 1'b0; rand_delay = 1'b0;
    test_tx_run(32'h2000_0000, wd, 1'b1);
  endtask

  task automatic test_random();
    int b, dc, dn, sv; logic e1; logic [DW-1:0] wd;
    rand_ready = 1'b1; rand_delay = 1'b1;
    for (int it = 0; it < 2; it++) begin
      rd_base = $urandom & 32'hFFFF_F000;
      sv = stab_viol; b = log_addr.size();
      do_xfer(1'b1, 1'b0, rd_base, 32'h0, '0, 1'b0, dc, dn, e1);
      n_assert++;
      if (dma_rx_data !== rx_pattern() || dma_error !== 1'b0 || log_addr.size() - b !== NB) begin
        n_fail++; $display("FAIL rand_rx data_lo=%h err=%b reqs=%0d want %h/0/%0d",
                           dma_rx_data[63:0], dma_error, log_addr.size() - b, 64'hA5000001_A5000000, NB);
      end
      n_assert++;
      if (stab_viol !== sv) begin n_fail++; $display("FAIL rand_stable got %0d violations want 0", stab_viol - sv); end
      for (int k = 0; k < NB; k++) wd[32*k +: 32] = $urandom;
      test_tx_run($urandom & 32'hFFFF_FFFC, wd, 1'b0);
    end
    // address wrap across the top of the 32-bit space
    for (int k = 0; k < NB; k++) wd[32*k +: 32] = $urandom;
    test_tx_run(32'hFFFF_FFC0, wd, 1'b0);
    rand_ready = 1'b0; rand_delay = 1'b0;
    n_assert++;
    if (stab_viol !== 0) begin n_fail++; $display("FAIL stable_total got %0d violations want 0", stab_viol); end
  endtask

  task automatic test_rsp_err();
    int b, dc, dn; logic e1;
    rd_base = 32'h1000_0000;
    err_at = rsp_total + 7;
    b = log_addr.size();
    do_xfer(1'b1, 1'b0, 32'h1000_0000, 32'h0, '0, 1'b0, dc, dn, e1);
    err_at = -1;
    n_assert++;
    if (log_addr.size() - b !== 8) begin n_fail++; $display("FAIL err_req_count got %0d want 8", log_addr.size() - b); end
    n_assert++;
    if (dn !== 1 || dma_error !== 1'b1) begin n_fail++; $display("FAIL err_done got cnt=%0d err=%b want 1/1", dn, dma_error); end
    n_assert++;
    if (dma_rx_data !== rx_pattern()) begin n_fail++; $display("FAIL err_rx_kept got %h want %h", dma_rx_data[63:0], 64'hA5000001_A5000000); end
    do_xfer(1'b1, 1'b0, 32'h1000_0000, 32'h0, '0, 1'b0, dc, dn, e1);
    n_assert++;
    if (e1 !== 1'b0 || dma_error !== 1'b0) begin n_fail++; $display("FAIL err_cleared got c1=%b end=%b want 0/0", e1, dma_error); end
  endtask

  task automatic test_collision_misaligned();
    int b, nw, dc, dn; logic e1; logic [DW-1:0] wd;
    for (int k = 0; k < NB; k++) wd[32*k +: 32] = $urandom;
    b = log_addr.size();
    do_xfer(1'b1, 1'b1, 32'h1000_0000, 32'h3000_0000, wd, 1'b0, dc, dn, e1);
    nw = 0;
    for (int k = b; k < log_addr.size(); k++) if (log_we[k]) nw++;
    n_assert++;
    if (nw !== 0 || log_addr.size() - b !== NB || dma_rx_data !== rx_pattern()) begin
      n_fail++; $display("FAIL collision got writes=%0d reqs=%0d want 0/%0d", nw, log_addr.size() - b, NB);
    end
    b = log_addr.size();
    do_xfer(1'b1, 1'b0, 32'h1000_0002, 32'h0, '0, 1'b0, dc, dn, e1);
    n_assert++;
    if (dc !== 1 || dn !== 1 || dma_error !== 1'b1 || log_addr.size() !== b) begin
      n_fail++; $display("FAIL misaligned_rx got cyc=%0d cnt=%0d err=%b reqs=%0d want 1/1/1/0", dc, dn, dma_error, log_addr.size() - b);
    end
    do_xfer(1'b0, 1'b1, 32'h0, 32'h2000_0001, wd, 1'b0, dc, dn, e1);
    n_assert++;
    if (dc !== 1 || dma_error !== 1'b1 || log_addr.size() !== b) begin
      n_fail++; $display("FAIL misaligned_tx got cyc=%0d err=%b reqs=%0d want 1/1/0", dc, dma_error, log_addr.size() - b);
    end
  endtask

  task automatic test_reset_mid();
    int r0, dc, dn; logic e1; bit ok;
    rd_base = 32'h1000_0000;
    r0 = rsp_total;
    @(negedge clk);
    dma_rx_address = 32'h1000_0000; dma_rx_start = 1'b1;
    @(negedge clk);
    dma_rx_start = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (rsp_total - r0 >= 10) begin ok = 1'b1; break; end
    end
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL mid_progress got %0d responses want 10", rsp_total - r0); end
    resetn = 1'b0;
    @(negedge clk);
    n_assert++;
    if (mem_req_valid !== 1'b0 || dma_idle !== 1'b1 || dma_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got valid=%b idle=%b done=%b want 0/1/0", mem_req_valid, dma_idle, dma_done);
    end
    resetn = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (mem_req_valid !== 1'b0 || dma_idle !== 1'b1 || dma_done !== 1'b0) ok = 1'b0;
    end
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL late_rsp_ignored got activity in idle want none"); end
    do_xfer(1'b1, 1'b0, 32'h1000_0000, 32'h0, '0, 1'b0, dc, dn, e1);
    n_assert++;
    if (dc !== 65 || dma_rx_data !== rx_pattern()) begin
      n_fail++; $display("FAIL after_mid_reset got cyc=%0d data_lo=%h want 65/%h", dc, dma_rx_data[63:0], 64'hA5000001_A5000000);
    end
  endtask

`ifdef DMA_TIMEOUT_EN
  task automatic test_timeout();
    int b, dc, dn; logic e1;
    hold = 1'b1;
    b = log_addr.size();
    do_xfer(1'b1, 1'b0, 32'h1000_0000, 32'h0, '0, 1'b0, dc, dn, e1);
    hold = 1'b0;
    n_assert++;
    if (dc !== 18 || dn !== 1 || dma_error !== 1'b1 || log_addr.size() - b !== 1) begin
      n_fail++; $display("FAIL timeout got cyc=%0d cnt=%0d err=%b reqs=%0d want 18/1/1/1", dc, dn, dma_error, log_addr.size() - b);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rx_basic();
    test_tx();
    test_random();
    test_rsp_err();
    test_collision_misaligned();
    test_reset_mid();
`ifdef DMA_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
